// File: rtl/dffsr_pipe_if.sv
// dffsr_pipe_if: data-path bundle for the dffsr_pipe delay line.
//   in_valid / in_data   : word entering stage 0 (driven by the master)
//   out_valid / out_data : word leaving the output stage (driven by the pipe)
//   occupancy            : count of stages currently holding a valid word
// The master modport belongs to the producer/consumer side, the slave
// modport to the pipeline itself.
interface dffsr_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface

// File: rtl/dffsr_pipe.sv
// dffsr_pipe: DEPTH-stage, WIDTH-bit delay line with a valid bit per stage
// and an occupancy counter.
//   clk        : rising-edge clock
//   arst       : asynchronous reset, active-high (loads RST_VAL, clears valids)
//   srst       : synchronous reset, active-high, wins over en
//   en         : clock enable for every stage and the counter
//   aset/aclr  : per-bit asynchronous set/clear of the output stage data only;
//                aclr wins over aset, arst wins over both
//   bus        : slave side of dffsr_pipe_if (in_valid/in_data in,
//                out_valid/out_data/occupancy out)
module dffsr_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] aset,
  input  logic [WIDTH-1:0] aclr,
  dffsr_pipe_if.slave      bus
);

  localparam int               OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  // Word that moves into the output stage on an enabled edge.
  logic [WIDTH-1:0] tail_s;

  // Stages 0..DEPTH-2 carry no set/clear, so they live in one plain register
  // bank; with DEPTH=1 the input feeds the output stage directly.
  generate
    if (DEPTH > 1) begin : g_mid
      logic [DEPTH-2:0][WIDTH-1:0] mid_q;
      logic [DEPTH-2:0][WIDTH-1:0] mid_d;

      // Next state of the inner stages: srst, then shift on en, else hold.
      always_comb begin
        mid_d = mid_q;
        if (srst) begin
          mid_d = {(DEPTH-1){RST_VAL}};
        end else if (en) begin
          mid_d[0] = bus.in_data;
          for (int k = 1; k < DEPTH - 1; k++) begin
            mid_d[k] = mid_q[k-1];
          end
        end else begin
          mid_d = mid_q;
        end
      end

      // Inner stage registers with asynchronous reset.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          mid_q <= {(DEPTH-1){RST_VAL}};
        end else begin
          mid_q <= mid_d;
        end
      end

      assign tail_s = mid_q[DEPTH-2];
    end else begin : g_nomid
      assign tail_s = bus.in_data;
    end
  endgenerate

  // Next state of valid bits, occupancy and output-stage data.
  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    out_d   = out_q;
    if (srst) begin
      valid_d = {DEPTH{1'b0}};
      occ_d   = {OCC_W{1'b0}};
      out_d   = RST_VAL;
    end else if (en) begin
      valid_d[0] = bus.in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
      end
      out_d = tail_s;
      // Occupancy moves only when exactly one of entry/exit carries a word,
      // which keeps it equal to the number of set valid bits.
      case ({bus.in_valid, valid_q[DEPTH-1]})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end else begin
      valid_d = valid_q;
      occ_d   = occ_q;
      out_d   = out_q;
    end
  end

  // Valid bits and occupancy counter; never touched by aset/aclr.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= {DEPTH{1'b0}};
      occ_q   <= {OCC_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Output stage: one flop per bit so each bit gets its own set and clear.
  // A forced value is stored in the flop, so it persists after release
  // until the next loading edge (hold reloads out_q itself).
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_out
      logic bit_q;
      logic set_s;
      logic clr_s;

      assign set_s = aset[i];
      assign clr_s = aclr[i];

      // Output bit i: arst > aclr > aset > clocked next state.
      always_ff @(posedge clk or posedge arst or posedge clr_s or posedge set_s) begin
        if (arst) begin
          bit_q <= RST_VAL[i];
        end else if (clr_s) begin
          bit_q <= 1'b0;
        end else if (set_s) begin
          bit_q <= 1'b1;
        end else begin
          bit_q <= out_d[i];
        end
      end

      assign out_q[i] = bit_q;
    end
  endgenerate

  assign bus.out_data  = out_q;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule

// File: doc/dffsr_pipe.md
# dffsr_pipe

Parametrised register pipeline: a DEPTH-stage, WIDTH-bit delay line built from asynchronously resettable flip-flops. It adds a clock enable, a synchronous reset, per-bit asynchronous set/clear on the output stage, a valid bit travelling with each word, and an occupancy counter. It is the generalised successor of the single-bit DFF/DFFSR test modules, intended as a synthesis/simulation regression block for reset- and set/clear-priority inference across widths and depths.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of pipeline stages (>= 1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage by arst and srst
- clk  input  1  rising-edge clock
- arst  input  1  reset arst, asynchronous, active-high; clock clk
- srst  input  1  synchronous reset, active-high
- en  input  1  clock enable for all stages and the counter
- in_valid  input  1  qualifies in_data
- in_data  input  WIDTH  data into stage 0
- aset  input  WIDTH  per-bit asynchronous set of the output stage, active-high
- aclr  input  WIDTH  per-bit asynchronous clear of the output stage, active-high
- out_valid  output  1  valid bit of stage DEPTH-1
- out_data  output  WIDTH  data of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  number of stages holding valid=1

## Operation
- Stage k (0..DEPTH-1) holds data[k] and valid[k]. out_data = data[DEPTH-1], out_valid = valid[DEPTH-1].
- Priority per rising clk edge, highest first: arst, then srst, then en, else hold.
- arst=1: all data[k] = RST_VAL, all valid[k] = 0, occupancy = 0, immediately and without a clock edge; held while arst=1.
- srst=1 (arst=0): same values as arst, taken at the clock edge, regardless of en.
- en=1: data[0] <= in_data, valid[0] <= in_valid; data[k] <= data[k-1], valid[k] <= valid[k-1] for k >= 1. Data shifts even when its valid bit is 0.
- en=0: all stages, valid bits and occupancy hold.
- occupancy always equals the popcount of valid[]. It updates on an enabled edge by +1 (in_valid=1, valid[DEPTH-1]=0), -1 (in_valid=0, valid[DEPTH-1]=1), or 0 otherwise. It never exceeds DEPTH or drops below 0.
- Output-stage async set/clear, per bit i of data[DEPTH-1]:
  - Priority: arst > aclr[i] > aset[i] > clocked behaviour.
  - aclr[i]=1 forces bit i to 0 and aset[i]=1 forces it to 1, immediately and while asserted. aclr wins when both are asserted; this is a defined case, not X.
  - After release, the bit holds its forced value until the next edge that loads stage DEPTH-1 (en=1 or srst=1).
  - aset/aclr affect neither valid[] nor occupancy, nor any stage other than DEPTH-1.
- DEPTH=1: stage 0 is the output stage, so aset/aclr act on it directly.

## Timing
- Latency: exactly DEPTH enabled edges from in_data/in_valid to out_data/out_valid. Cycles with en=0 stretch the latency and drop no data.
- Throughput: one word per enabled cycle; there is no backpressure.
- arst assertion is asynchronous. arst deassertion takes effect at the first clk edge after the fall; that edge behaves normally (srst/en).
- aset/aclr act combinationally on the output-stage flops (zero-cycle effect on out_data).
- Reset values of outputs: out_data = RST_VAL, out_valid = 0, occupancy = 0.
- A mid-stream arst or srst discards all in-flight words. The first word accepted afterwards appears DEPTH enabled edges later.

## Test plan
- WIDTH=8, DEPTH=4, RST_VAL=8'hA5: assert arst with no clk toggling -> out_data=8'hA5, out_valid=0, occupancy=0 immediately.
- en=1, drive in_valid=1 with 8'h01..8'h06 on six consecutive edges -> 8'h01 appears on the 4th edge, one word per edge afterwards; occupancy reads 1,2,3,4,4,4.
- Same stream with en=0 for 2 cycles mid-stream -> outputs and occupancy frozen for those 2 cycles; every word still arrives, in order, 2 cycles later.
- out_data=8'h00: aset=8'hF0 -> out_data=8'hF0 without a clock edge. Then aclr=8'h30 with aset still asserted -> 8'hC0. Release both with en=0 -> 8'hC0 holds. Next enabled edge -> the shifted-in value appears.
- Pipeline full (occupancy=4), srst=1 with en=0 on one edge -> all stages = 8'hA5, occupancy=0, out_valid=0 after that edge.
- DEPTH=1, WIDTH=1, RST_VAL=0: toggle d every edge with arst pulses between edges -> q follows d with 1-cycle latency and reads 0 during each arst pulse.
